alarm_ctrl: RTL and testbench
=============================

// Module: alarm_ctrl
// PURPOSE
//  Alarm controller that sits directly downstream of digital_clk.
//  - Consumes its seconds/minutes/hours outputs and holds a user-set alarm time.
//  - Drives a ring request when the alarm time is reached.
//  - Supports snooze, stop and ring timeout.
//  - Counts time only by watching the clock's seconds value change; no separate tick input.
// PARAMETERS
//  RING_SEC    60  ring duration in second ticks before auto-return to IDLE (1..255)
//  SNOOZE_MIN  5   snooze length in minutes; counted as SNOOZE_MIN*60 second ticks (1..60)
//  MAX_SNOOZE  3   snoozes allowed per alarm event; used only when ALARM_SNOOZE_LIMIT_EN is defined
// PORTS
//  clk          in   1  system clock, rising edge
//  rst          in   1  asynchronous, active-high reset
//  seconds      in   6  current seconds from digital_clk, 0..59
//  minutes      in   6  current minutes from digital_clk, 0..59
//  hours        in   5  current hours from digital_clk, 0..23
//  set_en       in   1  one-cycle strobe: load set_hours/set_minutes as alarm time
//  set_hours    in   5  alarm hours to load
//  set_minutes  in   6  alarm minutes to load
//  arm          in   1  level; 1 = alarm enabled
//  snooze       in   1  one-cycle strobe: snooze request
//  stop         in   1  one-cycle strobe: dismiss alarm
//  alarm_on     out  1  1 while ringing (registered)
//  snoozing     out  1  1 while snooze countdown runs (registered)
//  alm_hours    out  5  stored alarm hours
//  alm_minutes  out  6  stored alarm minutes
// BEHAVIOUR
//  - Reset (async, immediate):
//    - state = IDLE; alarm_on = 0; snoozing = 0
//    - alm_hours = 0; alm_minutes = 0
//    - prev_sec = 0; ring/snooze counters = 0
//  - Tick: tick = (seconds != prev_sec); prev_sec <= seconds every cycle.
//    - Ticks may occur on every cycle and must all be counted.
//  - Match: arm & tick & seconds==0 & hours==alm_hours & minutes==alm_minutes.
//  - FSM, all transitions on the clk edge; outputs reflect the new state from the next cycle:
//    - IDLE:   match -> RING, ring_cnt = 0.
//    - RING:   alarm_on = 1.
//      - stop -> IDLE.
//      - else snooze -> SNOOZE, snz_cnt = SNOOZE_MIN*60.
//      - else tick -> ring_cnt++; reaching RING_SEC -> IDLE.
//    - SNOOZE: snoozing = 1, alarm_on = 0.
//      - stop -> IDLE.
//      - else tick -> snz_cnt--; reaching 0 -> RING, ring_cnt = 0.
//      - snooze strobe in SNOOZE is ignored.
//  - Priority within RING/SNOOZE: arm==0 > stop > snooze > tick.
//    - arm==0 in any state forces IDLE next cycle.
//  - Latency: alarm_on rises 1 cycle after the cycle in which seconds first reads 0 at matching hh:mm.
//  - Set:
//    - set_en with set_hours<24 and set_minutes<60 loads alm_* on that edge.
//    - Out-of-range values are ignored entirely; alm_* unchanged.
//    - Loading never changes FSM state.
//    - Match uses the new value from the next cycle.
//  - Re-match: while RING/SNOOZE, a further match is ignored; no restart.
//  - Counter widths: ring_cnt 8 bits; snz_cnt 12 bits (max 3600).
// CONFIGURATION
//  - ALARM_SNOOZE_LIMIT_EN defined:
//    - 2-bit snz_used counter, cleared on IDLE->RING.
//    - snooze in RING is honoured only while snz_used < MAX_SNOOZE, then snz_used++.
//    - Otherwise the strobe is ignored and ringing continues.
//  - Undefined: unlimited snoozes; no snz_used logic present.
// TESTING
//  1 rst=1 at any state -> alarm_on=0, snoozing=0, alm_hours=0, alm_minutes=0 with no clk edge.
//  2 set 06:30, arm=1; drive 06:29:59 then 06:30:00 -> alarm_on=1 one cycle later;
//    after 60 further second ticks -> alarm_on=0, IDLE.
//  3 in RING pulse snooze -> snoozing=1, alarm_on=0; after 300 ticks -> alarm_on=1, snoozing=0.
//  4 in RING pulse stop and snooze same cycle -> IDLE, both outputs 0; arm=0 in SNOOZE -> IDLE.
//  5 set_en with 24:10, then 12:60 -> alm_* unchanged;
//    set_en with 23:59 during RING -> alm_*=23:59, alarm_on stays 1.
//  6 ALARM_SNOOZE_LIMIT_EN: snooze 3 times OK -> 4th snooze ignored, alarm_on stays 1;
//    without the macro the 4th snooze is honoured.

Source files
------------

// File: rtl/alarm_ctrl.sv
// alarm_ctrl: alarm controller that sits downstream of digital_clk.
// It watches the clock's seconds value for changes (ticks), raises alarm_on
// when the stored alarm hh:mm is reached at second 0, and supports stop,
// snooze, and an automatic ring timeout.
// Optional feature: define ALARM_SNOOZE_LIMIT_EN to cap the number of snoozes
// per alarm event at MAX_SNOOZE. Without the macro, snoozes are unlimited.
module alarm_ctrl #(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_MIN = 5
`ifdef ALARM_SNOOZE_LIMIT_EN
  ,
  parameter int MAX_SNOOZE = 3
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] seconds,
  input  logic [5:0] minutes,
  input  logic [4:0] hours,
  input  logic       set_en,
  input  logic [4:0] set_hours,
  input  logic [5:0] set_minutes,
  input  logic       arm,
  input  logic       snooze,
  input  logic       stop,
  output logic       alarm_on,
  output logic       snoozing,
  output logic [4:0] alm_hours,
  output logic [5:0] alm_minutes
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } state_t;

  localparam logic [7:0]  RING_LAST = 8'(RING_SEC - 1);
  localparam logic [11:0] SNZ_LOAD  = 12'(SNOOZE_MIN * 60);

  state_t      state;
  logic [5:0]  prev_sec;
  logic [7:0]  ring_cnt;
  logic [11:0] snz_cnt;
  logic        tick;
  logic        match;
  logic        snooze_ok;
`ifdef ALARM_SNOOZE_LIMIT_EN
  logic [1:0]  snz_used;
`endif

  // Tick detection, alarm match, and snooze permission.
  always_comb begin
    tick  = (seconds != prev_sec);
    match = arm & tick & (seconds == 6'd0) &
            (hours == alm_hours) & (minutes == alm_minutes);
`ifdef ALARM_SNOOZE_LIMIT_EN
    snooze_ok = ({30'd0, snz_used} < 32'(MAX_SNOOZE));
`else
    snooze_ok = 1'b1;
`endif
  end

  // Remember the last seconds value so each change counts as one tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_sec <= 6'd0;
    end else begin
      prev_sec <= seconds;
    end
  end

  // Alarm time storage; out-of-range loads are dropped entirely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alm_hours   <= 5'd0;
      alm_minutes <= 6'd0;
    end else if (set_en && (set_hours < 5'd24) && (set_minutes < 6'd60)) begin
      alm_hours   <= set_hours;
      alm_minutes <= set_minutes;
    end else begin
      alm_hours   <= alm_hours;
      alm_minutes <= alm_minutes;
    end
  end

  // Ring/snooze state machine with registered outputs that track the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      alarm_on <= 1'b0;
      snoozing <= 1'b0;
      ring_cnt <= 8'd0;
      snz_cnt  <= 12'd0;
`ifdef ALARM_SNOOZE_LIMIT_EN
      snz_used <= 2'd0;
`endif
    end else if (!arm) begin
      // Disarming cancels any ringing or snooze immediately.
      state    <= IDLE;
      alarm_on <= 1'b0;
      snoozing <= 1'b0;
      ring_cnt <= 8'd0;
      snz_cnt  <= 12'd0;
    end else begin
      case (state)
        IDLE: begin
          if (match) begin
            state    <= RING;
            alarm_on <= 1'b1;
            snoozing <= 1'b0;
            ring_cnt <= 8'd0;
`ifdef ALARM_SNOOZE_LIMIT_EN
            snz_used <= 2'd0;
`endif
          end else begin
            alarm_on <= 1'b0;
            snoozing <= 1'b0;
          end
        end
        RING: begin
          if (stop) begin
            state    <= IDLE;
            alarm_on <= 1'b0;
            snoozing <= 1'b0;
            ring_cnt <= 8'd0;
          end else if (snooze && snooze_ok) begin
            state    <= SNOOZE;
            alarm_on <= 1'b0;
            snoozing <= 1'b1;
            snz_cnt  <= SNZ_LOAD;
`ifdef ALARM_SNOOZE_LIMIT_EN
            snz_used <= snz_used + 2'd1;
`endif
          end else if (tick) begin
            if (ring_cnt >= RING_LAST) begin
              // Ring timed out without user action.
              state    <= IDLE;
              alarm_on <= 1'b0;
              snoozing <= 1'b0;
              ring_cnt <= 8'd0;
            end else begin
              ring_cnt <= ring_cnt + 8'd1;
            end
          end else begin
            ring_cnt <= ring_cnt;
          end
        end
        SNOOZE: begin
          // A snooze strobe here has no effect; only stop or expiry leave.
          if (stop) begin
            state    <= IDLE;
            alarm_on <= 1'b0;
            snoozing <= 1'b0;
            snz_cnt  <= 12'd0;
          end else if (tick) begin
            if (snz_cnt <= 12'd1) begin
              state    <= RING;
              alarm_on <= 1'b1;
              snoozing <= 1'b0;
              snz_cnt  <= 12'd0;
              ring_cnt <= 8'd0;
            end else begin
              snz_cnt <= snz_cnt - 12'd1;
            end
          end else begin
            snz_cnt <= snz_cnt;
          end
        end
        default: begin
          state    <= IDLE;
          alarm_on <= 1'b0;
          snoozing <= 1'b0;
          ring_cnt <= 8'd0;
          snz_cnt  <= 12'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed self-checking bench for alarm_ctrl (default parameters).
module tb_alarm_ctrl;

  logic       clk;
  logic       rst;
  logic [5:0] seconds;
  logic [5:0] minutes;
  logic [4:0] hours;
  logic       set_en;
  logic [4:0] set_hours;
  logic [5:0] set_minutes;
  logic       arm;
  logic       snooze;
  logic       stop;
  logic       alarm_on;
  logic       snoozing;
  logic [4:0] alm_hours;
  logic [5:0] alm_minutes;

  int vectors;
  int miscompares;
  int cur_h;
  int cur_m;
  int cur_s;

  alarm_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .seconds    (seconds),
    .minutes    (minutes),
    .hours      (hours),
    .set_en     (set_en),
    .set_hours  (set_hours),
    .set_minutes(set_minutes),
    .arm        (arm),
    .snooze     (snooze),
    .stop       (stop),
    .alarm_on   (alarm_on),
    .snoozing   (snoozing),
    .alm_hours  (alm_hours),
    .alm_minutes(alm_minutes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_time();
    seconds = 6'(cur_s);
    minutes = 6'(cur_m);
    hours   = 5'(cur_h);
  endtask

  // Advance the wall clock by n seconds, one tick per cycle.
  task automatic advance(input int n);
    for (int i = 0; i < n; i++) begin
      cur_s++;
      if (cur_s == 60) begin
        cur_s = 0;
        cur_m++;
        if (cur_m == 60) begin
          cur_m = 0;
          cur_h = (cur_h + 1) % 24;
        end
      end
      drive_time();
      cyc();
    end
  endtask

  task automatic set_alarm(input int h, input int m);
    set_en      = 1'b1;
    set_hours   = 5'(h);
    set_minutes = 6'(m);
    cyc();
    set_en      = 1'b0;
  endtask

  task automatic pulse_snooze();
    snooze = 1'b1;
    cyc();
    snooze = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  // Load alarm h:m (m >= 1), jump to one second before it, then tick into it.
  task automatic go_ring(input int h, input int m);
    set_alarm(h, m);
    cur_h = h;
    cur_m = m - 1;
    cur_s = 59;
    drive_time();
    cyc();
    advance(1);
    if (alarm_on !== 1'b1 || snoozing !== 1'b0) begin
      $display("FAIL go_ring %0d:%0d alarm_on=%b snoozing=%b want 1/0", h, m, alarm_on, snoozing);
      miscompares++;
    end
    vectors++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    if (alarm_on !== 1'b0 || snoozing !== 1'b0 || alm_hours !== 5'd0 || alm_minutes !== 6'd0) begin
      $display("FAIL reset_state got %b %b %0d:%0d want 0 0 0:0", alarm_on, snoozing, alm_hours, alm_minutes);
      miscompares++;
    end
    vectors++;
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_ring_timeout();
    set_alarm(6, 30);
    if (alm_hours !== 5'd6 || alm_minutes !== 6'd30) begin
      $display("FAIL set_0630 got %0d:%0d want 6:30", alm_hours, alm_minutes);
      miscompares++;
    end
    vectors++;
    cur_h = 6; cur_m = 29; cur_s = 58;
    drive_time();
    cyc();
    advance(1);
    if (alarm_on !== 1'b0) begin
      $display("FAIL pre_match alarm_on=%b want 0", alarm_on);
      miscompares++;
    end
    vectors++;
    advance(1);
    if (alarm_on !== 1'b1) begin
      $display("FAIL match_latency alarm_on=%b want 1", alarm_on);
      miscompares++;
    end
    vectors++;
    advance(59);
    if (alarm_on !== 1'b1) begin
      $display("FAIL ring_59_ticks alarm_on=%b want 1", alarm_on);
      miscompares++;
    end
    vectors++;
    advance(1);
    if (alarm_on !== 1'b0 || snoozing !== 1'b0) begin
      $display("FAIL ring_timeout got %b %b want 0 0", alarm_on, snoozing);
      miscompares++;
    end
    vectors++;
  endtask

  task automatic test_snooze();
    go_ring(7, 15);
    pulse_snooze();
    if (snoozing !== 1'b1 || alarm_on !== 1'b0) begin
      $display("FAIL snooze_enter got snoozing=%b alarm_on=%b want 1 0", snoozing, alarm_on);
      miscompares++;
    end
    vectors++;
    pulse_snooze();
    advance(299);
    if (snoozing !== 1'b1 || alarm_on !== 1'b0) begin
      $display("FAIL snooze_299 got snoozing=%b alarm_on=%b want 1 0", snoozing, alarm_on);
      miscompares++;
    end
    vectors++;
    advance(1);
    if (snoozing !== 1'b0 || alarm_on !== 1'b1) begin
      $display("FAIL snooze_expire got snoozing=%b alarm_on=%b want 0 1", snoozing, alarm_on);
      miscompares++;
    end
    vectors++;
  endtask

  task automatic test_stop_disarm();
    stop   = 1'b1;
    snooze = 1'b1;
    cyc();
    stop   = 1'b0;
    snooze = 1'b0;
    if (alarm_on !== 1'b0 || snoozing !== 1'b0) begin
      $display("FAIL stop_over_snooze got %b %b want 0 0", alarm_on, snoozing);
      miscompares++;
    end
    vectors++;
    go_ring(8, 20);
    pulse_snooze();
    arm = 1'b0;
    cyc();
    if (alarm_on !== 1'b0 || snoozing !== 1'b0) begin
      $display("FAIL disarm_snooze got %b %b want 0 0", alarm_on, snoozing);
      miscompares++;
    end
    vectors++;
    arm = 1'b1;
    advance(400);
    if (alarm_on !== 1'b0 || snoozing !== 1'b0) begin
      $display("FAIL disarm_stays_idle got %b %b want 0 0", alarm_on, snoozing);
      miscompares++;
    end
    vectors++;
  endtask

  task automatic test_set_range();
    set_alarm(24, 10);
    if (alm_hours !== 5'd8 || alm_minutes !== 6'd20) begin
      $display("FAIL set_bad_hour got %0d:%0d want 8:20", alm_hours, alm_minutes);
      miscompares++;
    end
    vectors++;
    set_alarm(12, 60);
    if (alm_hours !== 5'd8 || alm_minutes !== 6'd20) begin
      $display("FAIL set_bad_min got %0d:%0d want 8:20", alm_hours, alm_minutes);
      miscompares++;
    end
    vectors++;
    go_ring(9, 5);
    set_alarm(23, 59);
    if (alm_hours !== 5'd23 || alm_minutes !== 6'd59 || alarm_on !== 1'b1) begin
      $display("FAIL set_in_ring got %0d:%0d alarm_on=%b want 23:59 1", alm_hours, alm_minutes, alarm_on);
      miscompares++;
    end
    vectors++;
    pulse_stop();
    if (alarm_on !== 1'b0) begin
      $display("FAIL stop_ring alarm_on=%b want 0", alarm_on);
      miscompares++;
    end
    vectors++;
  endtask

  task automatic test_snooze_limit();
    go_ring(10, 10);
    for (int k = 0; k < 3; k++) begin
      pulse_snooze();
      if (snoozing !== 1'b1) begin
        $display("FAIL snooze_n%0d snoozing=%b want 1", k + 1, snoozing);
        miscompares++;
      end
      vectors++;
      advance(300);
      if (alarm_on !== 1'b1) begin
        $display("FAIL resnooze_ring%0d alarm_on=%b want 1", k + 1, alarm_on);
        miscompares++;
      end
      vectors++;
    end
    pulse_snooze();
`ifdef ALARM_SNOOZE_LIMIT_EN
    if (alarm_on !== 1'b1 || snoozing !== 1'b0) begin
      $display("FAIL snooze_4th_limited got %b %b want 1 0", alarm_on, snoozing);
      miscompares++;
    end
`else
    if (alarm_on !== 1'b0 || snoozing !== 1'b1) begin
      $display("FAIL snooze_4th_unlimited got %b %b want 0 1", alarm_on, snoozing);
      miscompares++;
    end
`endif
    vectors++;
    pulse_stop();
  endtask

  task automatic test_async_reset();
    go_ring(11, 45);
    #2;
    rst = 1'b1;
    #1;
    if (alarm_on !== 1'b0 || snoozing !== 1'b0 || alm_hours !== 5'd0 || alm_minutes !== 6'd0) begin
      $display("FAIL async_reset got %b %b %0d:%0d want 0 0 0:0", alarm_on, snoozing, alm_hours, alm_minutes);
      miscompares++;
    end
    vectors++;
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cur_h = 0; cur_m = 0; cur_s = 0;
    seconds = 6'd0; minutes = 6'd0; hours = 5'd0;
    set_en = 1'b0; set_hours = 5'd0; set_minutes = 6'd0;
    arm = 1'b1; snooze = 1'b0; stop = 1'b0;
    rst = 1'b1;
    test_reset();
    test_ring_timeout();
    test_snooze();
    test_stop_disarm();
    test_set_range();
    test_snooze_limit();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
